axi3_slave_mem: RTL
===================

// Module: axi3_slave_mem
// PURPOSE
//  Active AXI3 slave responder backed by an internal word-addressed memory; the responder end of the AXI3 master bus.
//  Independent write (AW/W/B) and read (AR/R) engines; one outstanding burst per direction; no write interleaving.
//  Serves as a bus-side target in block-level benches and as a scratch RAM in the subsystem.
// PARAMETERS
//  ADDR_W    32   address width
//  DATA_W    64   data width (fixed 64; STRB_W = 8)
//  ID_W      9    AXI ID width
//  MEM_WORDS 1024 memory depth in DATA_W words; index = addr[3 +: $clog2(MEM_WORDS)]
// PORTS  (aw*/ar* share width and meaning per direction)
//  aclk               in   1       clock, rising edge
//  areset             in   1       async reset, active-high
//  awvalid / arvalid  in   1       address valid
//  awready / arready  out  1       address ready
//  awaddr / araddr    in   ADDR_W  byte start address
//  awlen / arlen      in   4       beats-1
//  awsize / arsize    in   3       bytes/beat = 1<<size
//  awburst / arburst  in   2       00 FIXED, 01 INCR, 10 WRAP
//  awid / arid        in   ID_W    transaction ID
//  wvalid / wready    in/out 1     write data handshake
//  wdata              in   64      write data
//  wstrb              in   8       byte lane enables
//  wid                in   ID_W    write data ID
//  wlast              in   1       last write beat
//  bvalid / bready    out/in 1     write response handshake
//  bresp / bid        out  2/ID_W  write response, echoes awid
//  rvalid / rready    out/in 1     read data handshake
//  rdata              out  64      read data (full word)
//  rresp / rid        out  2/ID_W  per-beat response, echoes arid
//  rlast              out  1       last read beat
//  buser / ruser      out  32      only with AXI_SLV_USER_EN
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0; FSMs to IDLE; memory contents NOT cleared. Reset mid-burst abandons it with no response.
//  Write FSM: W_IDLE(awready=1) -AW hs-> W_DATA(wready=1) -final beat hs-> W_RESP(bvalid=1) -bready-> W_IDLE.
//   Burst ends after exactly awlen+1 W handshakes; bvalid holds until bready; awready=1 again the cycle after B hs.
//  Read FSM: R_IDLE(arready=1) -AR hs-> R_DATA; first rvalid the cycle after AR hs; beat n+1 after each R hs.
//   rvalid/rdata/rresp/rlast stable while rready=0; rlast=1 on beat arlen only; arready=1 the cycle after final R hs.
//  Address gen: FIXED holds; INCR adds 1<<size; WRAP wraps in (len+1)<<size aligned window. 32-bit add, wrap-around ignored.
//  Write beat: bytes with wstrb=1 written; wstrb=0 lanes unchanged. Read returns full 64-bit word.
//  SLVERR (resp 2'b10) conditions, sticky per write burst, per beat on read:
//   word index >= MEM_WORDS (write beat suppressed, rdata=0); size>3; burst=11 or WRAP len not in {1,3,7,15}
//   (both treated as INCR); wid!=awid (beat suppressed); wlast value disagrees with beat count.
//  awlock/cache/prot not ported; response never EXOKAY. Same-cycle read+write to one word: read returns old data.
// CONFIGURATION
//  AXI_SLV_USER_EN defined: buser/ruser ports exist; awuser/aruser inputs latched at AW/AR hs and echoed on B/all R beats.
//  Undefined: buser, ruser, awuser, aruser ports absent.
// STRUCTURE
//  axi_slv_pkg: burst_e {FIXED,INCR,WRAP}, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, wr_state_e, rd_state_e.
//  Sub-module axi_burst_addr_gen (addr,len,size,burst -> next addr, illegal flag), instanced once per direction.
// TESTING
//  INCR write awaddr=0x40 len=3 size=3 data 0x11..0x44, then read same -> bresp=OKAY, 4 R beats 0x11..0x44, rlast on 4th.
//  WRAP read araddr=0x18 len=3 size=3 -> word order 0x18,0x00,0x08,0x10.
//  wstrb=0x0F onto word 0xFFFF_FFFF_FFFF_FFFF with wdata 0 -> read 0xFFFF_FFFF_0000_0000.
//  awaddr=MEM_WORDS*8 -> bresp=SLVERR, memory unchanged; read there -> rresp=SLVERR, rdata=0.
//  rready low 5 cycles mid-burst -> rdata/rlast stable; areset during W_DATA -> all outputs 0, awready=1 next cycle after release.

Source files
------------

// File: rtl/axi_slv_pkg.sv
// Shared types for the AXI3 slave memory: burst encodings, response codes and FSM states.
package axi_slv_pkg;
    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction
endpackage

// File: rtl/axi3_slave_mem_if.sv
// AXI3 bus bundle between a master and the slave memory.
// User sideband signals exist only when AXI_SLV_USER_EN is defined.
interface axi3_slave_mem_if #(parameter int ADDR_W = 32, parameter int ID_W = 9);
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [ID_W-1:0]   awid;
    logic              wvalid, wready, wlast;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic [ID_W-1:0]   wid;
    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [ID_W-1:0]   arid;
    logic              rvalid, rready, rlast;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic [ID_W-1:0]   rid;
`ifdef AXI_SLV_USER_EN
    logic [31:0]       awuser, aruser, buser, ruser;
`endif

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid, wvalid, wdata, wstrb, wid, wlast, bready,
               arvalid, araddr, arlen, arsize, arburst, arid, rready,
`ifdef AXI_SLV_USER_EN
        input  awuser, aruser,
        output buser, ruser,
`endif
        output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid, rlast
    );

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid, wvalid, wdata, wstrb, wid, wlast, bready,
               arvalid, araddr, arlen, arsize, arburst, arid, rready,
`ifdef AXI_SLV_USER_EN
        output awuser, aruser,
        input  buser, ruser,
`endif
        input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rid, rlast
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts; reserved bursts and bad WRAP lengths step as INCR
// and raise the illegal flag, as does a beat size wider than the 64-bit bus.
module axi_burst_addr_gen
    import axi_slv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              illegal
);
    logic [ADDR_W-1:0] step, mask, incr;
    logic              bad_burst;

    always_comb begin
        step      = ADDR_W'(1) << size;
        mask      = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        incr      = addr + step;
        bad_burst = (burst == 2'b11) || ((burst == WRAP) && !wrap_len_ok(len));
        illegal   = bad_burst || (size > 3'd3);
        if (burst == FIXED)
            next_addr = addr;
        else if ((burst == WRAP) && !bad_burst)
            next_addr = (addr & ~mask) | (incr & mask);
        else
            next_addr = incr;
    end
endmodule

// File: rtl/axi3_slave_mem.sv
// AXI3 slave backed by a word-addressed RAM: independent write and read engines, one burst each.
// Define AXI_SLV_USER_EN to latch awuser/aruser and echo them on buser/ruser.
module axi3_slave_mem
    import axi_slv_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 9,
    parameter int MEM_WORDS = 1024
) (
    input  logic             aclk,
    input  logic             areset,
    axi3_slave_mem_if.slave  s
);
    localparam int                STRB_W    = DATA_W / 8;
    localparam int                OFS       = $clog2(STRB_W);
    localparam int                IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * STRB_W);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    wr_state_e         w_state;
    logic [ADDR_W-1:0] w_addr, wg_addr, w_next;
    logic [3:0]        w_len, wg_len, w_cnt;
    logic [2:0]        w_size, wg_size;
    logic [1:0]        w_burst, wg_burst;
    logic [ID_W-1:0]   w_id;
    logic              w_err, wg_illegal, w_hs, w_final, w_oob, w_id_bad, w_beat_err, mem_we;

    rd_state_e         r_state;
    logic [ADDR_W-1:0] r_addr, rg_addr, r_next, r_fetch;
    logic [3:0]        r_len, rg_len, r_cnt;
    logic [2:0]        r_size, rg_size;
    logic [1:0]        r_burst, rg_burst;
    logic              rg_illegal, r_fetch_oob;
    logic [DATA_W-1:0] r_fetch_data;

    // While idle the generators look at the incoming address phase so the illegal flag is ready at the handshake.
    assign wg_addr  = (w_state == W_IDLE) ? s.awaddr  : w_addr;
    assign wg_len   = (w_state == W_IDLE) ? s.awlen   : w_len;
    assign wg_size  = (w_state == W_IDLE) ? s.awsize  : w_size;
    assign wg_burst = (w_state == W_IDLE) ? s.awburst : w_burst;
    assign rg_addr  = (r_state == R_IDLE) ? s.araddr  : r_addr;
    assign rg_len   = (r_state == R_IDLE) ? s.arlen   : r_len;
    assign rg_size  = (r_state == R_IDLE) ? s.arsize  : r_size;
    assign rg_burst = (r_state == R_IDLE) ? s.arburst : r_burst;

    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wgen (
        .addr(wg_addr), .len(wg_len), .size(wg_size), .burst(wg_burst),
        .next_addr(w_next), .illegal(wg_illegal));
    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rgen (
        .addr(rg_addr), .len(rg_len), .size(rg_size), .burst(rg_burst),
        .next_addr(r_next), .illegal(rg_illegal));

    assign w_hs       = (w_state == W_DATA) && s.wvalid && s.wready;
    assign w_final    = (w_cnt == w_len);
    assign w_oob      = (w_addr >= MEM_BYTES);
    assign w_id_bad   = (s.wid != w_id);
    assign w_beat_err = w_oob || w_id_bad || (s.wlast != w_final);
    assign mem_we     = w_hs && !w_oob && !w_id_bad;

    assign r_fetch      = (r_state == R_IDLE) ? s.araddr : r_next;
    assign r_fetch_oob  = (r_fetch >= MEM_BYTES);
    assign r_fetch_data = r_fetch_oob ? '0 : mem[r_fetch[OFS +: IDX_W]];

    // Memory is deliberately outside the reset domain so contents survive areset.
    always_ff @(posedge aclk)
        if (mem_we)
            for (int b = 0; b < STRB_W; b++)
                if (s.wstrb[b]) mem[w_addr[OFS +: IDX_W]][8*b +: 8] <= s.wdata[8*b +: 8];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state   <= W_IDLE;
            s.awready <= 1'b0;
            s.wready  <= 1'b0;
            s.bvalid  <= 1'b0;
            s.bresp   <= RESP_OKAY;
            s.bid     <= '0;
            w_addr    <= '0;
            w_len     <= '0;
            w_size    <= '0;
            w_burst   <= '0;
            w_id      <= '0;
            w_cnt     <= '0;
            w_err     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    s.awready <= 1'b1;
                    if (s.awvalid && s.awready) begin
                        s.awready <= 1'b0;
                        s.wready  <= 1'b1;
                        w_addr    <= s.awaddr;
                        w_len     <= s.awlen;
                        w_size    <= s.awsize;
                        w_burst   <= s.awburst;
                        w_id      <= s.awid;
                        w_cnt     <= '0;
                        w_err     <= wg_illegal;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: if (w_hs) begin
                    w_err  <= w_err | w_beat_err;
                    w_addr <= w_next;
                    w_cnt  <= w_cnt + 4'd1;
                    // Beat count, not wlast, closes the burst.
                    if (w_final) begin
                        s.wready <= 1'b0;
                        s.bvalid <= 1'b1;
                        s.bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        s.bid    <= w_id;
                        w_state  <= W_RESP;
                    end
                end
                W_RESP: if (s.bready) begin
                    s.bvalid  <= 1'b0;
                    s.awready <= 1'b1;
                    w_state   <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= R_IDLE;
            s.arready <= 1'b0;
            s.rvalid  <= 1'b0;
            s.rdata   <= '0;
            s.rresp   <= RESP_OKAY;
            s.rid     <= '0;
            s.rlast   <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    s.arready <= 1'b1;
                    if (s.arvalid && s.arready) begin
                        s.arready <= 1'b0;
                        r_addr    <= s.araddr;
                        r_len     <= s.arlen;
                        r_size    <= s.arsize;
                        r_burst   <= s.arburst;
                        r_cnt     <= '0;
                        s.rid     <= s.arid;
                        s.rvalid  <= 1'b1;
                        s.rlast   <= (s.arlen == 4'd0);
                        s.rdata   <= r_fetch_data;
                        s.rresp   <= (rg_illegal || r_fetch_oob) ? RESP_SLVERR : RESP_OKAY;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: if (s.rvalid && s.rready) begin
                    if (s.rlast) begin
                        s.rvalid  <= 1'b0;
                        s.rlast   <= 1'b0;
                        s.arready <= 1'b1;
                        r_state   <= R_IDLE;
                    end else begin
                        r_addr  <= r_next;
                        r_cnt   <= r_cnt + 4'd1;
                        s.rlast <= ((r_cnt + 4'd1) == r_len);
                        s.rdata <= r_fetch_data;
                        s.rresp <= (rg_illegal || r_fetch_oob) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

`ifdef AXI_SLV_USER_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s.buser <= '0;
            s.ruser <= '0;
        end else begin
            if ((w_state == W_IDLE) && s.awvalid && s.awready) s.buser <= s.awuser;
            if ((r_state == R_IDLE) && s.arvalid && s.arready) s.ruser <= s.aruser;
        end
    end
`endif
endmodule
